multiport_regfile: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined RV32I core and its wider/dual-issue variants.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_clear_seq.sv | 62 ++++++
 rtl/multiport_regfile.sv | 95 +++++++++
 tb/tb_multiport_regfile.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: sweep FSM encoding,
// address-width derivation and packed port-slice helpers.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Address width for a register count; a single-entry file still needs one bit.
  function automatic int rf_aw(input int nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

  // LSB of port `port` inside a flat bus of `width`-bit fields.
  function automatic int rf_slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Self-timed clear sweep: after reset or a soft clear request, walks every
// entry once, issuing a zero write per clock, then reports READY.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output rf_state_e     state_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e     state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          // The last entry is written on the same edge that enters READY.
          if (idx_q == LAST_IDX) begin
            state_q <= RF_READY;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        RF_READY: begin
          if (clr_req_i) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= RF_CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = (state_q == RF_CLEAR);
  assign clr_addr_o = idx_q;
  assign state_o    = state_q;

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multi-port integer register file with optional write-to-read
// bypass, hardwired zero entry and a sweep-based clear on reset/request.
module multiport_regfile
  import rf_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_req,
  output logic                     init_busy,
  input  logic [NWR-1:0]           we,
  input  logic [NWR*rf_aw(NREGS)-1:0] wa,
  input  logic [NWR*XLEN-1:0]      wd,
  input  logic [NRD*rf_aw(NREGS)-1:0] ra,
  output logic [NRD*XLEN-1:0]      rd
);

  localparam int AW = rf_aw(NREGS);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  rf_state_e       sweep_state;

  logic [XLEN-1:0] regs_q [NREGS];

  logic [AW-1:0]   wa_a  [NWR];
  logic [XLEN-1:0] wd_a  [NWR];
  logic [NWR-1:0]  wen;
  logic            user_ok;

  rf_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_req_i  (clr_req),
    .busy_o     (init_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .state_o    (sweep_state)
  );

  // User writes only land in READY, and not on the edge that starts a sweep.
  assign user_ok = (sweep_state == RF_READY) && !clr_req;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wa_a[k] = wa[rf_slice_lsb(k, AW) +: AW];
      wd_a[k] = wd[rf_slice_lsb(k, XLEN) +: XLEN];
      wen[k]  = user_ok && we[k] && !((ZERO_REG != 0) && (wa_a[k] == '0));
    end
  end

  // Later loop iterations override earlier ones, giving the higher port priority.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_addr] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wen[k]) begin
          regs_q[wa_a[k]] <= wd_a[k];
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int j = 0; j < NRD; j++) begin
      logic [AW-1:0]   ra_j;
      logic [XLEN-1:0] val;
      ra_j = ra[rf_slice_lsb(j, AW) +: AW];
      val  = regs_q[ra_j];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wen[k] && (wa_a[k] == ra_j)) begin
            val = wd_a[k];
          end
        end
      end
      if ((sweep_state != RF_READY) || ((ZERO_REG != 0) && (ra_j == '0))) begin
        val = '0;
      end
      rd[rf_slice_lsb(j, XLEN) +: XLEN] = val;
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: a two-write-port bypassing file and a one-write-port
// non-bypassing file share clock, reset and clear request.
module tb_multiport_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_req;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [63:0] nb_rd;
  logic        busy;
  logic        nb_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  always #5 clk = ~clk;

  multiport_regfile #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .init_busy(busy),
    .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd)
  );

  multiport_regfile #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .reset(reset), .clr_req(clr_req), .init_busy(nb_busy),
    .we(we[0:0]), .wa(wa[4:0]), .wd(wd[31:0]), .ra(ra), .rd(nb_rd)
  );

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [31:0] e_nb0;
    logic [31:0] e_nb1;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Counts negedges with init_busy high; optionally issues a write mid-sweep.
  task automatic wait_ready(input logic drop_write, output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      if (drop_write && cycles == 5) begin
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h77}; ra = {5'd9, 5'd9};
        #1;
        check("sweep_rd0_zero", rd[31:0], 32'h0);
        check("sweep_nb_rd0_zero", nb_rd[31:0], 32'h0);
      end else begin
        we = 2'b00;
      end
      cycles++;
      @(negedge clk);
    end
    we = 2'b00;
  endtask

  initial begin
    reset = 1'b1; clr_req = 1'b0; we = '0; wa = '0; wd = '0; ra = {5'd5, 5'd5};

    vecs[0]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    5'd0,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,    5'd5,  5'd1,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,    5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{2'b01, 5'd7,  32'hA5A5A5A5, 5'd0,  32'h0,    5'd5,  5'd7,  32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
    vecs[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7]  = '{2'b11, 5'd3,  32'h1111,     5'd3,  32'h2222, 5'd3,  5'd3,  32'h2222,     32'h2222,     32'h0,        32'h0};
    vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    5'd3,  5'd7,  32'h2222,     32'hA5A5A5A5, 32'h1111,     32'hA5A5A5A5};
    vecs[9]  = '{2'b10, 5'd9,  32'h0,        5'd9,  32'h55,   5'd9,  5'd3,  32'h55,       32'h2222,     32'h0,        32'h1111};
    vecs[10] = '{2'b01, 5'd9,  32'h55,       5'd0,  32'h0,    5'd9,  5'd9,  32'h55,       32'h55,       32'h0,        32'h0};
    vecs[11] = '{2'b11, 5'd12, 32'hAAAA,     5'd13, 32'hBBBB, 5'd12, 5'd13, 32'hAAAA,     32'hBBBB,     32'h0,        32'h0};
    vecs[12] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    5'd12, 5'd13, 32'hAAAA,     32'hBBBB,     32'hAAAA,     32'h0};
    vecs[13] = '{2'b11, 5'd4,  32'h4444,     5'd0,  32'h9999, 5'd4,  5'd0,  32'h4444,     32'h0,        32'h0,        32'h0};
    vecs[14] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    5'd4,  5'd0,  32'h4444,     32'h0,        32'h4444,     32'h0};

    // Reset and power-up sweep.
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'h1);
    check("rst_rd0", rd[31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(1'b0, cyc);
    check("init_busy_clocks", cyc, 32);
    check("nb_busy_after_init", {31'd0, nb_busy}, 32'h0);

    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #1;
      check($sformatf("init_zero_x%0d", a), rd[31:0], 32'h0);
      check($sformatf("init_zero_nb_x%0d", a), nb_rd[63:32], 32'h0);
      @(negedge clk);
    end

    // Table-driven writes, bypass, zero register and collisions.
    for (int i = 0; i < 15; i++) begin
      we = vecs[i].we;
      wa = {vecs[i].wa1, vecs[i].wa0};
      wd = {vecs[i].wd1, vecs[i].wd0};
      ra = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("v%0d_rd0", i), rd[31:0], vecs[i].e_rd0);
      check($sformatf("v%0d_rd1", i), rd[63:32], vecs[i].e_rd1);
      check($sformatf("v%0d_nb_rd0", i), nb_rd[31:0], vecs[i].e_nb0);
      check($sformatf("v%0d_nb_rd1", i), nb_rd[63:32], vecs[i].e_nb1);
      @(negedge clk);
    end
    we = '0;

    // Soft clear with a dropped write during the sweep.
    ra = {5'd5, 5'd9};
    #1;
    check("pre_clr_x9", rd[31:0], 32'h55);
    clr_req = 1'b1;
    check("clr_req_cycle_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    clr_req = 1'b0;
    wait_ready(1'b1, cyc);
    check("clr_busy_clocks", cyc, 32);
    ra = {5'd5, 5'd9};
    #1;
    check("post_clr_x9", rd[31:0], 32'h0);
    check("post_clr_x5", rd[63:32], 32'h0);
    check("post_clr_nb_x9", nb_rd[31:0], 32'h0);
    @(negedge clk);

    // Reset mid-sweep at idx 17 restarts the full sweep.
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(1'b0, cyc);
    check("restart_busy_clocks", cyc, 32);

    // Held clear request re-arms once per READY entry.
    clr_req = 1'b1;
    @(negedge clk);
    wait_ready(1'b0, cyc);
    check("held_clr_busy_clocks", cyc, 32);
    check("held_clr_ready_gap", {31'd0, busy}, 32'h0);
    @(negedge clk);
    check("held_clr_rearm", {31'd0, busy}, 32'h1);
    clr_req = 1'b0;
    @(negedge clk);
    wait_ready(1'b0, cyc);
    check("final_ready", {31'd0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
